// File: rtl/lcd1602_frame_ctrl.sv
// Frame-buffered LCD1602 sequencer: 32-char shadow buffer, one-shot init, dirty-only streaming.
// Latency: one cycle per scanned position; each byte costs one driver handshake (ISSUE/ACK/DONE).
// Backpressure: writes never stall; the driver is throttled only through drv_busy.
module lcd1602_frame_ctrl #(
  parameter int CLK_FRE  = 20,
  parameter int PWRUP_US = 15000,
  parameter int CLR_US   = 2000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic       fill_en,
  input  logic [7:0] fill_char,
  output logic       init_done,
  output logic       idle,
  output logic       drv_en,
  output logic       drv_rs,
  output logic [7:0] drv_data,
  input  logic       drv_busy
);

  // PWR_WAIT ends one cycle early because INIT spends one cycle before the
  // first drv_en, so that pulse lands exactly CLK_FRE*PWRUP_US cycles after reset.
  localparam logic [31:0] PWR_LAST = 32'(CLK_FRE * PWRUP_US - 2);
  localparam logic [31:0] CLR_LAST = 32'(CLK_FRE * CLR_US - 1);

  localparam logic [3:0] S_PWR_WAIT  = 4'd0;
  localparam logic [3:0] S_INIT      = 4'd1;
  localparam logic [3:0] S_CLR_WAIT  = 4'd2;
  localparam logic [3:0] S_SCAN      = 4'd3;
  localparam logic [3:0] S_SEND_ADDR = 4'd4;
  localparam logic [3:0] S_SEND_DATA = 4'd5;
  localparam logic [3:0] S_ISSUE     = 4'd6;
  localparam logic [3:0] S_ACK       = 4'd7;
  localparam logic [3:0] S_DONE      = 4'd8;

  // Shadow buffer and per-position dirty flags
  logic [7:0]  shadow_q [32];
  logic [7:0]  shadow_d [32];
  logic [31:0] dirty_q, dirty_d;
  logic [31:0] wr_hit;
  logic [31:0] scan_clr;

  // Sequencer state
  logic [3:0]  state_q, state_d;
  logic [3:0]  ret_q, ret_d;
  logic [31:0] timer_q, timer_d;
  logic [1:0]  init_idx_q, init_idx_d;
  logic [4:0]  ptr_q, ptr_d;
  logic [4:0]  pos_q, pos_d;
  logic [7:0]  ch_q, ch_d;
  logic [4:0]  cursor_q, cursor_d;
  logic        cursor_vld_q, cursor_vld_d;
  logic        init_done_q, init_done_d;
  logic        drv_en_q, drv_en_d;
  logic        drv_rs_q, drv_rs_d;
  logic [7:0]  drv_data_q, drv_data_d;

  logic        latch_go;

  // Power-up command list: 8-bit/2-line, display on, entry increment, clear.
  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h38;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  assign latch_go = (state_q == S_SCAN) && dirty_q[ptr_q];
  assign scan_clr = latch_go ? (32'd1 << ptr_q) : 32'd0;

  // User writes: fill first, then the single write overrides its position;
  // a write in the latch cycle re-sets the dirty flag the scanner is clearing.
  always_comb begin
    wr_hit = 32'd0;
    for (int i = 0; i < 32; i++) begin
      shadow_d[i] = shadow_q[i];
    end
    if (fill_en) begin
      for (int i = 0; i < 32; i++) begin
        shadow_d[i] = fill_char;
      end
      wr_hit = 32'hFFFF_FFFF;
    end
    if (wr_en) begin
      shadow_d[wr_addr] = wr_char;
      wr_hit[wr_addr]   = 1'b1;
    end
    dirty_d = (dirty_q & ~scan_clr) | wr_hit;
  end

  // Buffer and dirty registers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        shadow_q[i] <= 8'h20;
      end
      dirty_q <= 32'd0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      dirty_q <= dirty_d;
    end
  end

  // Sequencer next-state: init, scan for dirty positions, driver handshake
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    timer_d      = timer_q;
    init_idx_d   = init_idx_q;
    ptr_d        = ptr_q;
    pos_d        = pos_q;
    ch_d         = ch_q;
    cursor_d     = cursor_q;
    cursor_vld_d = cursor_vld_q;
    init_done_d  = init_done_q;
    drv_en_d     = 1'b0;
    drv_rs_d     = drv_rs_q;
    drv_data_d   = drv_data_q;

    case (state_q)
      S_PWR_WAIT: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == PWR_LAST) begin
          timer_d = 32'd0;
          state_d = S_INIT;
        end
      end

      S_INIT: begin
        if (!drv_busy) begin
          drv_en_d   = 1'b1;
          drv_rs_d   = 1'b0;
          drv_data_d = init_cmd(init_idx_q);
          ret_d      = S_INIT;
          state_d    = S_ISSUE;
        end
      end

      S_CLR_WAIT: begin
        timer_d = timer_q + 32'd1;
        if (timer_q == CLR_LAST) begin
          timer_d      = 32'd0;
          init_done_d  = 1'b1;
          cursor_d     = 5'd0;
          cursor_vld_d = 1'b1;
          state_d      = S_SCAN;
        end
      end

      S_SCAN: begin
        // Character is taken from the buffer before any same-cycle write lands.
        if (dirty_q[ptr_q]) begin
          pos_d   = ptr_q;
          ch_d    = shadow_q[ptr_q];
          state_d = (cursor_vld_q && (cursor_q == ptr_q)) ? S_SEND_DATA : S_SEND_ADDR;
        end else if (dirty_q != 32'd0) begin
          // Hold position when clean so the next change is found from the last send point.
          ptr_d = ptr_q + 5'd1;
        end
      end

      S_SEND_ADDR: begin
        if (!drv_busy) begin
          drv_en_d   = 1'b1;
          drv_rs_d   = 1'b0;
          drv_data_d = {1'b1, pos_q[4], 2'b00, pos_q[3:0]};
          ret_d      = S_SEND_ADDR;
          state_d    = S_ISSUE;
        end
      end

      S_SEND_DATA: begin
        if (!drv_busy) begin
          drv_en_d   = 1'b1;
          drv_rs_d   = 1'b1;
          drv_data_d = ch_q;
          ret_d      = S_SEND_DATA;
          state_d    = S_ISSUE;
        end
      end

      S_ISSUE: begin
        state_d = S_ACK;
      end

      S_ACK: begin
        if (drv_busy) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (!drv_busy) begin
          case (ret_q)
            S_INIT: begin
              if (init_idx_q == 2'd3) begin
                timer_d = 32'd0;
                state_d = S_CLR_WAIT;
              end else begin
                init_idx_d = init_idx_q + 2'd1;
                state_d    = S_INIT;
              end
            end
            S_SEND_ADDR: begin
              cursor_d     = pos_q;
              cursor_vld_d = 1'b1;
              state_d      = S_SEND_DATA;
            end
            S_SEND_DATA: begin
              // Auto-increment past column 15 leaves the visible line.
              if (pos_q[3:0] == 4'hF) begin
                cursor_vld_d = 1'b0;
              end else begin
                cursor_d = pos_q + 5'd1;
              end
              ptr_d   = pos_q + 5'd1;
              state_d = S_SCAN;
            end
            default: state_d = S_SCAN;
          endcase
        end
      end

      default: state_d = S_PWR_WAIT;
    endcase
  end

  // Sequencer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_PWR_WAIT;
      ret_q        <= S_PWR_WAIT;
      timer_q      <= 32'd0;
      init_idx_q   <= 2'd0;
      ptr_q        <= 5'd0;
      pos_q        <= 5'd0;
      ch_q         <= 8'h00;
      cursor_q     <= 5'd0;
      cursor_vld_q <= 1'b0;
      init_done_q  <= 1'b0;
      drv_en_q     <= 1'b0;
      drv_rs_q     <= 1'b0;
      drv_data_q   <= 8'h00;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      timer_q      <= timer_d;
      init_idx_q   <= init_idx_d;
      ptr_q        <= ptr_d;
      pos_q        <= pos_d;
      ch_q         <= ch_d;
      cursor_q     <= cursor_d;
      cursor_vld_q <= cursor_vld_d;
      init_done_q  <= init_done_d;
      drv_en_q     <= drv_en_d;
      drv_rs_q     <= drv_rs_d;
      drv_data_q   <= drv_data_d;
    end
  end

  assign init_done = init_done_q;
  assign drv_en    = drv_en_q;
  assign drv_rs    = drv_rs_q;
  assign drv_data  = drv_data_q;
  assign idle      = (state_q == S_SCAN) && init_done_q && (dirty_q == 32'd0);

endmodule

// File: tb/tb_lcd1602_frame_ctrl.sv
// Directed bench for lcd1602_frame_ctrl with a busy-for-8-cycles driver model.
// Latency: checks exact init timing; streams are compared byte-by-byte.
// Backpressure: the driver model holds drv_busy high after every drv_en.
module tb_lcd1602_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       fill_en;
  logic [7:0] fill_char;
  logic       init_done;
  logic       idle;
  logic       drv_en;
  logic       drv_rs;
  logic [7:0] drv_data;
  logic       drv_busy = 1'b0;

  lcd1602_frame_ctrl #(.CLK_FRE(20), .PWRUP_US(10), .CLR_US(5)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_char(wr_char),
    .fill_en(fill_en), .fill_char(fill_char),
    .init_done(init_done), .idle(idle),
    .drv_en(drv_en), .drv_rs(drv_rs), .drv_data(drv_data),
    .drv_busy(drv_busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       rs;
    logic [7:0] dat;
    int         cyc;
  } ev_t;

  typedef struct packed {
    logic [1:0]      n_wr;
    logic [4:0]      a0;
    logic [7:0]      c0;
    logic [4:0]      a1;
    logic [7:0]      c1;
    logic [2:0]      n_exp;
    logic [3:0][8:0] exp;
  } vec_t;

  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          bcnt = 0;
  ev_t         ev_q[$];
  logic [8:0]  exp_q[$];
  vec_t        vecs[4];
  logic [7:0]  init_seq[4];

  always @(posedge clk) cyc++;

  // Monitor plus driver model: busy for 8 cycles after each accepted drv_en.
  always @(negedge clk) begin
    if (drv_en === 1'b1) begin
      ev_q.push_back('{rs: drv_rs, dat: drv_data, cyc: cyc});
      drv_busy = 1'b1;
      bcnt = 8;
    end else if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) drv_busy = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  function automatic ev_t ev_at(input int i);
    if (i < ev_q.size()) return ev_q[i];
    return '{rs: 1'b1, dat: 8'hFF, cyc: -1};
  endfunction

  function automatic logic [3:0][8:0] mk4(input logic [8:0] e0, e1, e2, e3);
    logic [3:0][8:0] r;
    r[0] = e0; r[1] = e1; r[2] = e2; r[3] = e3;
    return r;
  endfunction

  // Called at a negedge; the write is sampled by the following posedge.
  task automatic wr(input logic [4:0] a, input logic [7:0] c);
    wr_en = 1'b1; wr_addr = a; wr_char = c;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_events(input string name, input int n, input int budget);
    int k = 0;
    while (ev_q.size() < n && k < budget) begin @(negedge clk); k++; end
    chk({name, "_evt_timeout"}, 32'(ev_q.size() >= n), 32'd1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (idle !== 1'b1 && k < budget) begin @(negedge clk); k++; end
    chk({name, "_idle"}, 32'(idle), 32'd1);
  endtask

  task automatic wait_init(input string name, output int at);
    int k = 0;
    while (init_done !== 1'b1 && k < 2000) begin @(negedge clk); k++; end
    at = cyc;
    chk({name, "_init_timeout"}, 32'(init_done), 32'd1);
  endtask

  task automatic check_stream(input string name);
    ev_t e;
    chk({name, "_len"}, 32'(ev_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      e = ev_at(i);
      chk($sformatf("%s_ev%0d", name, i), {23'd0, e.rs, e.dat}, {23'd0, exp_q[i]});
    end
  endtask

  // Reset release edge r: first command at r+200, init_done 109 cycles after 0x01 drv_en
  // (busy clears 9 edges after the pulse, then 100 cycles of clear wait).
  task automatic check_init(input string name, input int r);
    ev_t e;
    int  at;
    wait_events(name, 4, 2000);
    e = ev_at(0);
    chk({name, "_first_cmd_cyc"}, 32'(e.cyc - r), 32'd200);
    for (int i = 0; i < 4; i++) begin
      e = ev_at(i);
      chk($sformatf("%s_cmd%0d", name, i), {23'd0, e.rs, e.dat}, {24'd0, init_seq[i]});
    end
    e = ev_at(3);
    wait_init(name, at);
    chk({name, "_init_done_cyc"}, 32'(at - e.cyc), 32'd109);
    chk({name, "_no_data_before_init"}, 32'(ev_q.size()), 32'd4);
    ev_q.delete();
  endtask

  initial begin
    int   e_cyc;
    int   r;
    ev_t  e;

    init_seq[0] = 8'h38; init_seq[1] = 8'h0C; init_seq[2] = 8'h06; init_seq[3] = 8'h01;
    // Table starts right after the init flush: cursor=2, scan position 2.
    vecs[0] = '{n_wr: 2'd2, a0: 5'd2, c0: 8'h43, a1: 5'd3, c1: 8'h44, n_exp: 3'd2,
                exp: mk4(9'h143, 9'h144, 9'h0, 9'h0)};
    vecs[1] = '{n_wr: 2'd1, a0: 5'd20, c0: 8'h58, a1: 5'd0, c1: 8'h00, n_exp: 3'd2,
                exp: mk4(9'h0C4, 9'h158, 9'h0, 9'h0)};
    vecs[2] = '{n_wr: 2'd1, a0: 5'd21, c0: 8'h59, a1: 5'd0, c1: 8'h00, n_exp: 3'd1,
                exp: mk4(9'h159, 9'h0, 9'h0, 9'h0)};
    vecs[3] = '{n_wr: 2'd2, a0: 5'd15, c0: 8'h50, a1: 5'd16, c1: 8'h51, n_exp: 3'd4,
                exp: mk4(9'h08F, 9'h150, 9'h0C0, 9'h151)};

    rst = 1'b1; wr_en = 1'b0; wr_addr = 5'd0; wr_char = 8'h00;
    fill_en = 1'b0; fill_char = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_drv_en", 32'(drv_en), 32'd0);
    chk("rst_drv_rs", 32'(drv_rs), 32'd0);
    chk("rst_drv_data", 32'(drv_data), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
    chk("rst_idle", 32'(idle), 32'd0);
    r = cyc;
    rst = 1'b0;

    // Writes during power-up wait stay dirty and flush after init with no address.
    wr(5'd0, 8'h41);
    wr(5'd1, 8'h42);
    check_init("init", r);
    wait_idle("flush", 2000);
    exp_q.delete(); exp_q.push_back(9'h141); exp_q.push_back(9'h142);
    check_stream("flush");

    for (int v = 0; v < 4; v++) begin
      ev_q.delete();
      wr(vecs[v].a0, vecs[v].c0);
      if (vecs[v].n_wr == 2'd2) wr(vecs[v].a1, vecs[v].c1);
      chk($sformatf("vec%0d_idle_drop", v), 32'(idle), 32'd0);
      wait_idle($sformatf("vec%0d", v), 2000);
      exp_q.delete();
      for (int i = 0; i < int'(vecs[v].n_exp); i++) exp_q.push_back(vecs[v].exp[i]);
      check_stream($sformatf("vec%0d", v));
    end

    // Fill plus single write in one cycle; scan resumes at 17 with cursor 17.
    ev_q.delete();
    fill_en = 1'b1; fill_char = 8'h2D; wr_en = 1'b1; wr_addr = 5'd5; wr_char = 8'h31;
    @(negedge clk);
    fill_en = 1'b0; wr_en = 1'b0;
    wait_idle("fill", 4000);
    exp_q.delete();
    for (int p = 17; p < 32; p++) exp_q.push_back(9'h12D);
    exp_q.push_back(9'h080);
    for (int p = 0; p < 16; p++) exp_q.push_back((p == 5) ? 9'h131 : 9'h12D);
    exp_q.push_back(9'h0C0);
    exp_q.push_back(9'h12D);
    check_stream("fill");

    // Rewrite position 3 exactly in its latch cycle: old value sent, then new one.
    ev_q.delete();
    wr(5'd2, 8'h61);
    wr(5'd3, 8'h62);
    wait_events("rewr", 2, 2000);
    e = ev_at(1);
    e_cyc = e.cyc;
    while (cyc < e_cyc + 9) @(negedge clk);
    wr(5'd3, 8'h63);
    wait_idle("rewr", 2000);
    exp_q.delete();
    exp_q.push_back(9'h082); exp_q.push_back(9'h161); exp_q.push_back(9'h162);
    exp_q.push_back(9'h083); exp_q.push_back(9'h163);
    check_stream("rewr");

    // Reset while the driver is busy with a data byte.
    ev_q.delete();
    wr(5'd9, 8'h52);
    wait_events("midrst", 2, 2000);
    repeat (3) @(negedge clk);
    chk("midrst_busy_model", 32'(drv_busy), 32'd1);
    chk("midrst_pre_rs", 32'(drv_rs), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    r = cyc;
    rst = 1'b0;
    chk("midrst_drv_en", 32'(drv_en), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_idle", 32'(idle), 32'd0);
    chk("midrst_drv_rs", 32'(drv_rs), 32'd0);
    chk("midrst_drv_data", 32'(drv_data), 32'd0);
    ev_q.delete();
    check_init("reinit", r);
    wait_idle("reinit", 2000);
    repeat (40) @(negedge clk);
    chk("reinit_no_stream", 32'(ev_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
